// File: rtl/layer_engine_pkg.sv
// Shared definitions for the layer-engine opcode dispatcher: unit ids,
// unit-field geometry inside a command word, and dispatcher state encoding.
package layer_engine_pkg;

  localparam int NUM_UNITS    = 5;
  localparam int UNIT_FIELD_W = 3;

  localparam logic [2:0] UNIT_CONV    = 3'd0;
  localparam logic [2:0] UNIT_ADD     = 3'd1;
  localparam logic [2:0] UNIT_POOL    = 3'd2;
  localparam logic [2:0] UNIT_ACT     = 3'd3;
  localparam logic [2:0] UNIT_OMAP    = 3'd4;
  localparam logic [2:0] UNIT_BARRIER = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_BARRIER = 2'd2,
    S_REPORT  = 2'd3
  } state_e;

  // The unit id occupies the top bits of a command word of width w.
  function automatic int unit_msb(input int w);
    return w - 1;
  endfunction

  function automatic int unit_lsb(input int w);
    return w - UNIT_FIELD_W;
  endfunction

endpackage

// File: rtl/layer_engine_outstanding_ctr.sv
// Per-unit count of issued-but-not-completed opcodes. An issue and a
// completion in the same cycle cancel; a completion at zero is flagged.
module layer_engine_outstanding_ctr #(
  parameter int C_MAX_OUTSTANDING = 4,
  parameter int CW                = $clog2(C_MAX_OUTSTANDING + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_nxt,
  output logic          full,
  output logic          zero,
  output logic          underflow
);

  localparam logic [CW-1:0] MAX_CNT = CW'(C_MAX_OUTSTANDING);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count from issue/completion events, saturating at both ends.
  always_comb begin
    count_d   = count_q;
    underflow = 1'b0;
    if (inc && !dec) begin
      if (count_q != MAX_CNT) count_d = count_q + CW'(1);
    end else if (!inc && dec) begin
      if (count_q == '0) underflow = 1'b1;
      else               count_d   = count_q - CW'(1);
    end
  end

  // Count register, cleared by the active-low synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign count     = count_q;
  assign count_nxt = count_d;
  assign full      = (count_q == MAX_CNT);
  assign zero      = (count_q == '0);

endmodule

// File: rtl/layer_engine_opcode_dispatch.sv
// Routes the controller's command stream onto five per-unit opcode lanes,
// tracks outstanding work per unit and implements a drain-all barrier.
import layer_engine_pkg::*;

module layer_engine_opcode_dispatch #(
  parameter int C_OPCODE_WIDTH    = 64,
  parameter int C_NUM_UNITS       = 5,
  parameter int C_MAX_OUTSTANDING = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  cmd_valid,
  output logic                                  cmd_accept,
  input  logic [C_OPCODE_WIDTH-1:0]             cmd_payload,
  output logic [C_NUM_UNITS*C_OPCODE_WIDTH-1:0] opcode,
  output logic [C_NUM_UNITS-1:0]                opcode_valid,
  input  logic [C_NUM_UNITS-1:0]                opcode_accept,
  input  logic [C_NUM_UNITS-1:0]                unit_done,
  output logic                                  status_valid,
  input  logic                                  status_accept,
  output logic [C_OPCODE_WIDTH-1:0]             status_payload,
  output logic                                  busy,
  output logic                                  err_bad_unit,
  output logic                                  err_underflow
);

  localparam int W    = C_OPCODE_WIDTH;
  localparam int UMSB = unit_msb(C_OPCODE_WIDTH);
  localparam int ULSB = unit_lsb(C_OPCODE_WIDTH);
  localparam int CW   = $clog2(C_MAX_OUTSTANDING + 1);

  state_e                          state_q;
  logic                            cmd_accept_q;
  logic [C_NUM_UNITS*W-1:0]        opcode_q;
  logic [C_NUM_UNITS-1:0]          opcode_valid_q;
  logic                            status_valid_q;
  logic [W-1:0]                    status_payload_q;
  logic                            busy_q;
  logic                            err_bad_unit_q;
  logic                            err_underflow_q;
  logic [W-1:0]                    word_q;
  logic [2:0]                      unit_q;

  logic [2:0]                      cmd_unit;
  logic [C_NUM_UNITS-1:0]          issue_hs;
  logic [C_NUM_UNITS-1:0]          full;
  logic [C_NUM_UNITS-1:0]          zero;
  logic [C_NUM_UNITS-1:0]          uflow;
  logic [C_NUM_UNITS-1:0]          nz_next;
  logic [CW-1:0]                   cnt     [C_NUM_UNITS];
  logic [CW-1:0]                   cnt_nxt [C_NUM_UNITS];

  assign cmd_unit = cmd_payload[UMSB:ULSB];
  assign issue_hs = opcode_valid_q & opcode_accept;

  for (genvar g = 0; g < C_NUM_UNITS; g++) begin : g_ctr
    layer_engine_outstanding_ctr #(
      .C_MAX_OUTSTANDING (C_MAX_OUTSTANDING),
      .CW                (CW)
    ) u_ctr (
      .clk       (clk),
      .rst       (rst),
      .inc       (issue_hs[g]),
      .dec       (unit_done[g]),
      .count     (cnt[g]),
      .count_nxt (cnt_nxt[g]),
      .full      (full[g]),
      .zero      (zero[g]),
      .underflow (uflow[g])
    );
    assign nz_next[g] = |cnt_nxt[g];
  end

  // Dispatcher FSM with all upstream/downstream outputs registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q          <= S_IDLE;
      cmd_accept_q     <= 1'b0;
      opcode_q         <= '0;
      opcode_valid_q   <= '0;
      status_valid_q   <= 1'b0;
      status_payload_q <= '0;
      busy_q           <= 1'b0;
      err_bad_unit_q   <= 1'b0;
      err_underflow_q  <= 1'b0;
      word_q           <= '0;
      unit_q           <= UNIT_CONV;
    end else begin
      // Idle-looking by default; states that stay active override below.
      busy_q <= |nz_next;
      if (|uflow) err_underflow_q <= 1'b1;

      unique case (state_q)
        S_IDLE: begin
          cmd_accept_q <= 1'b1;
          if (cmd_valid && cmd_accept_q) begin
            word_q <= cmd_payload;
            unit_q <= cmd_unit;
            if (cmd_unit <= UNIT_OMAP) begin
              state_q                    <= S_ISSUE;
              cmd_accept_q               <= 1'b0;
              busy_q                     <= 1'b1;
              opcode_q                   <= '0;
              opcode_q[int'(cmd_unit)*W +: W] <= cmd_payload;
              // A full unit keeps valid low until a completion frees a slot.
              opcode_valid_q[cmd_unit]   <= ~full[cmd_unit];
            end else if (cmd_unit == UNIT_BARRIER) begin
              state_q      <= S_BARRIER;
              cmd_accept_q <= 1'b0;
              busy_q       <= 1'b1;
            end else begin
              // Reserved ids 5 and 6 are dropped and remembered.
              err_bad_unit_q <= 1'b1;
            end
          end
        end

        S_ISSUE: begin
          if (issue_hs[unit_q]) begin
            opcode_valid_q <= '0;
            opcode_q       <= '0;
            state_q        <= S_IDLE;
            cmd_accept_q   <= 1'b1;
          end else begin
            busy_q <= 1'b1;
            if (!full[unit_q]) opcode_valid_q[unit_q] <= 1'b1;
          end
        end

        S_BARRIER: begin
          busy_q <= 1'b1;
          if (&zero) begin
            status_payload_q <= word_q;
            status_valid_q   <= 1'b1;
            state_q          <= S_REPORT;
          end
        end

        S_REPORT: begin
          if (status_accept) begin
            status_valid_q <= 1'b0;
            state_q        <= S_IDLE;
            cmd_accept_q   <= 1'b1;
          end else begin
            busy_q <= 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_accept     = cmd_accept_q;
  assign opcode         = opcode_q;
  assign opcode_valid   = opcode_valid_q;
  assign status_valid   = status_valid_q;
  assign status_payload = status_payload_q;
  assign busy           = busy_q;
  assign err_bad_unit   = err_bad_unit_q;
  assign err_underflow  = err_underflow_q;

endmodule
